// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared state type for the countdown timer
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } countdown_state_t;

endpackage

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - programmable down-counter with one-shot/auto-reload and run/pause/done control
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int VALUE_MAX = 7,
  parameter int W = $clog2(VALUE_MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         start,
  input  logic         stop,
  input  logic         enabled,
  input  logic         auto_reload,
  output logic [W-1:0] value,
  output logic         underflow,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0] VMAX = W'(VALUE_MAX);

  countdown_state_t state_q, state_d;
  logic [W-1:0]     value_q, value_d;
  logic [W-1:0]     reload_q, reload_d;
  logic             underflow_q, underflow_d;
  logic [W-1:0]     load_clamped;

  // Saturate out-of-range load values to the largest legal count
  always_comb begin
    load_clamped = load_value;
    if (32'(load_value) > VALUE_MAX) begin
      load_clamped = VMAX;
    end
  end

  // Next-state decode: load > stop > start > enabled tick
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    reload_d    = reload_q;
    underflow_d = 1'b0;
    if (load) begin
      value_d  = load_clamped;
      reload_d = load_clamped;
      state_d  = IDLE;
    end else if (stop && (state_q == RUN)) begin
      state_d = PAUSED;
    end else if (start && (state_q != RUN)) begin
      if (state_q == DONE) begin
        value_d = reload_q;
        state_d = RUN;
      end else if (value_q != '0) begin
        state_d = RUN;
      end else begin
        // Starting an already-expired count finishes immediately
        state_d     = DONE;
        underflow_d = 1'b1;
      end
    end else if ((state_q == RUN) && enabled) begin
      if (value_q != '0) begin
        value_d = value_q - 1'b1;
      end else begin
        underflow_d = 1'b1;
        if (auto_reload) begin
          value_d = reload_q;
        end else begin
          state_d = DONE;
        end
      end
    end
  end

  // Register all state; reset discards any wrap pending on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      value_q     <= '0;
      reload_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      reload_q    <= reload_d;
      underflow_q <= underflow_d;
    end
  end

  assign value     = value_q;
  assign underflow = underflow_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [2:0] load_value;
  logic       start;
  logic       stop;
  logic       enabled;
  logic       auto_reload;
  logic [2:0] value;
  logic       underflow;
  logic       busy;
  logic       done;
  logic [2:0] c_value;
  logic       c_underflow;
  logic       c_busy;
  logic       c_done;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  countdown_timer #(.VALUE_MAX(7)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .enabled(enabled), .auto_reload(auto_reload),
    .value(value), .underflow(underflow), .busy(busy), .done(done)
  );

  // Narrower range instance to exercise clamping within a 3-bit load port
  countdown_timer #(.VALUE_MAX(5)) u_clamp (
    .clk(clk), .rst_n(rst_n), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .enabled(enabled), .auto_reload(auto_reload),
    .value(c_value), .underflow(c_underflow), .busy(c_busy), .done(c_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] ar_value [9] = '{3'd1, 3'd0, 3'd2, 3'd1, 3'd0, 3'd2, 3'd1, 3'd0, 3'd2};
  logic       ar_uf    [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    // Reset with every input high
    rst_n = 1'b0; load = 1'b1; load_value = 3'd7; start = 1'b1; stop = 1'b1;
    enabled = 1'b1; auto_reload = 1'b1;
    tick();
    tick();
    check("rst_value", 32'(value), 0);
    check("rst_underflow", 32'(underflow), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    #2;
    check("rst_release_value", 32'(value), 0);
    check("rst_release_busy", 32'(busy), 0);
    check("rst_release_done", 32'(done), 0);
    load = 1'b0; start = 1'b0; stop = 1'b0; enabled = 1'b0; auto_reload = 1'b0;

    // One-shot from 3
    load = 1'b1; load_value = 3'd3;
    tick();
    load = 1'b0;
    check("os_load_value", 32'(value), 3);
    check("os_load_busy", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("os_start_value", 32'(value), 3);
    check("os_start_busy", 32'(busy), 1);
    enabled = 1'b1;
    tick();
    check("os_t1_value", 32'(value), 2);
    tick();
    check("os_t2_value", 32'(value), 1);
    tick();
    check("os_t3_value", 32'(value), 0);
    check("os_t3_underflow", 32'(underflow), 0);
    tick();
    check("os_t4_underflow", 32'(underflow), 1);
    check("os_t4_value", 32'(value), 0);
    check("os_t4_done", 32'(done), 1);
    check("os_t4_busy", 32'(busy), 0);
    tick();
    check("os_t5_underflow", 32'(underflow), 0);
    check("os_t5_done", 32'(done), 1);
    enabled = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("os_restart_value", 32'(value), 3);
    check("os_restart_busy", 32'(busy), 1);
    check("os_restart_done", 32'(done), 0);

    // Auto-reload from 2
    auto_reload = 1'b1; load = 1'b1; load_value = 3'd2;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; enabled = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("ar_t%0d_value", i + 1), 32'(value), 32'(ar_value[i]));
      check($sformatf("ar_t%0d_underflow", i + 1), 32'(underflow), 32'(ar_uf[i]));
      check($sformatf("ar_t%0d_busy", i + 1), 32'(busy), 1);
    end
    enabled = 1'b0; auto_reload = 1'b0;

    // Clamp: 7 fits VALUE_MAX=7, saturates to 5 on the narrow instance
    load = 1'b1; load_value = 3'd7;
    tick();
    load = 1'b0;
    check("clamp_main_value", 32'(value), 7);
    check("clamp_narrow_value", 32'(c_value), 5);

    // Pause at 5 with stop and enabled together
    start = 1'b1;
    tick();
    start = 1'b0; enabled = 1'b1;
    tick();
    tick();
    check("pause_pre_value", 32'(value), 5);
    stop = 1'b1;
    tick();
    stop = 1'b0; enabled = 1'b0;
    check("pause_value", 32'(value), 5);
    check("pause_busy", 32'(busy), 0);
    check("pause_done", 32'(done), 0);
    tick();
    check("pause_hold_value", 32'(value), 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("resume_busy", 32'(busy), 1);
    check("resume_value", 32'(value), 5);
    enabled = 1'b1;
    tick();
    check("resume_dec_value", 32'(value), 4);

    // Load beats start during RUN
    load = 1'b1; load_value = 3'd4; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    check("prio_value", 32'(value), 4);
    check("prio_busy", 32'(busy), 0);
    check("prio_done", 32'(done), 0);
    tick();
    check("prio_idle_hold", 32'(value), 4);
    enabled = 1'b0;

    // Start with a zero count
    load = 1'b1; load_value = 3'd0;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", 32'(done), 1);
    check("zero_underflow", 32'(underflow), 1);
    check("zero_busy", 32'(busy), 0);
    check("zero_value", 32'(value), 0);
    tick();
    check("zero_underflow_end", 32'(underflow), 0);

    // Reset on the edge that would wrap from 0
    load = 1'b1; load_value = 3'd1;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; enabled = 1'b1;
    tick();
    check("rwrap_pre_value", 32'(value), 0);
    check("rwrap_pre_busy", 32'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; enabled = 1'b0;
    check("rwrap_underflow", 32'(underflow), 0);
    check("rwrap_value", 32'(value), 0);
    check("rwrap_busy", 32'(busy), 0);
    check("rwrap_done", 32'(done), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
